cnn_layer_accel_weight_seq_ctrl: RTL and testbench
==================================================

CNN_LAYER_ACCEL_WEIGHT_SEQ_CTRL -- requirements
Module: cnn_layer_accel_weight_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a sequence run; sampled only in IDLE.
REQ-005 num_repeat  input  8  number of full 4-phase passes; sampled with start; value 0 treated as 1.
REQ-006 rdy  input  1  downstream pre-ready; consumer guarantees acceptance of the word returned one cycle after an issue cycle.
REQ-007 gray_code  output  2  phase select to weight sequence table.
REQ-008 seq_data_addr  output  3  entry index to weight sequence table, range 0..4.
REQ-009 wht_vld  output  1  qualifies the table's registered wht_data_addr in the current cycle.
REQ-010 busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 abort  input  1  synchronous run cancel; present only when CNN_LAYER_ACCEL_WSEQ_ABORT_EN is defined.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE -> RUN on start=1; latch num_repeat (0 -> 1); clear pass counter; gray_code=00, seq_data_addr=0.
REQ-015 An issue cycle SHALL be any cycle with state RUN and rdy=1; wht_vld SHALL be 1 exactly in the cycle after each issue cycle, 0 otherwise.
REQ-016 With rdy=0 in RUN, gray_code and seq_data_addr SHALL hold (table re-reads same entry; no wht_vld next cycle).
REQ-017 On issue, seq_data_addr SHALL increment; on issue at 4 it SHALL wrap to 0 and gray_code SHALL advance 00->01->11->10.
REQ-018 On issue at gray_code=10, seq_data_addr=4, the pass counter SHALL increment; if it equals the latched repeat count, next state DRAIN, else gray_code wraps to 00 and RUN continues.
REQ-019 DRAIN SHALL last exactly one cycle (carries the final wht_vld) then DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-020 Total wht_vld pulses per run SHALL equal 20 x effective repeat count.
REQ-021 start while not IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-022 Pass counter SHALL be 8 bits; 255 passes (5100 issues) SHALL complete without overflow.
REQ-023 In IDLE, DRAIN, DONE: gray_code=00, seq_data_addr=0 presented (DRAIN retains last values until DONE).

Reset
REQ-024 On rst_n=0, immediately and regardless of clk: state IDLE, gray_code=00, seq_data_addr=0, wht_vld=0, busy=0, done=0, pass counter=0.
REQ-025 Reset asserted mid-run SHALL discard the run with no done pulse; deassertion SHALL be synchronized so the first active edge after release sees IDLE.

Configuration
REQ-026 Macro CNN_LAYER_ACCEL_WSEQ_ABORT_EN SHALL compile in the abort port and logic.
REQ-027 With macro: abort=1 in RUN SHALL force DONE next cycle (done=1 pulse, no further issues, wht_vld for an issue in the abort cycle suppressed); abort ignored in IDLE/DRAIN/DONE.
REQ-028 Without macro: no abort port; run terminates only via REQ-018 or reset.

Verification
REQ-029 start=1, num_repeat=1, rdy=1 constant -> 20 wht_vld pulses; (gray,addr) order 00:0..4, 01:0..4, 11:0..4, 10:0..4; done 22 cycles after start cycle.
REQ-030 num_repeat=0 -> identical behaviour to num_repeat=1 (20 pulses, one done).
REQ-031 num_repeat=3, rdy toggling 1,0 each cycle -> exactly 60 wht_vld pulses, addresses never skipped or duplicated, outputs stable while rdy=0.
REQ-032 rst_n pulsed low at issue 7 of a run -> outputs zero asynchronously, no done, next start yields full fresh 20-issue sequence from 00:0.
REQ-033 start re-asserted during RUN and during DONE -> ignored; exactly one done per accepted start.
REQ-034 With CNN_LAYER_ACCEL_WSEQ_ABORT_EN, abort=1 at issue 10 (gray 01, addr 4) -> 9 wht_vld pulses, done next cycle, then IDLE.

Source files
------------

// File: rtl/cnn_layer_accel_weight_seq_ctrl_if.sv
// Handshake bundle between a run requester and the weight sequencer.
// Optional abort line present when CNN_LAYER_ACCEL_WSEQ_ABORT_EN is defined.
interface cnn_layer_accel_weight_seq_ctrl_if;
  logic       start;
  logic [7:0] num_repeat;
  logic       rdy;
`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
  logic       abort;
`endif
  logic [1:0] gray_code;
  logic [2:0] seq_data_addr;
  logic       wht_vld;
  logic       busy;
  logic       done;

`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
  modport master (
    output start, num_repeat, rdy, abort,
    input  gray_code, seq_data_addr, wht_vld, busy, done
  );
  modport slave (
    input  start, num_repeat, rdy, abort,
    output gray_code, seq_data_addr, wht_vld, busy, done
  );
`else
  modport master (
    output start, num_repeat, rdy,
    input  gray_code, seq_data_addr, wht_vld, busy, done
  );
  modport slave (
    input  start, num_repeat, rdy,
    output gray_code, seq_data_addr, wht_vld, busy, done
  );
`endif
endinterface

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// Weight sequence controller: walks the weight sequence table through four
// gray-coded phases (00,01,11,10) of five entries each, num_repeat times,
// advancing only when the consumer is ready. Each issue produces a wht_vld
// one cycle later, aligned with the table's registered read data.
// Optional run cancel compiled in with CNN_LAYER_ACCEL_WSEQ_ABORT_EN.
module cnn_layer_accel_weight_seq_ctrl (
  input logic clk,
  input logic rst_n,
  cnn_layer_accel_weight_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_ADDR = 3'd4;
  localparam logic [1:0] LAST_GRAY = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] gray_code_q, gray_code_d;
  logic [2:0] seq_data_addr_q, seq_data_addr_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] repeat_q, repeat_d;
  logic [7:0] pass_inc;
  logic       wht_vld_q, wht_vld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] sync_q;
  logic       abort_hit;

  // Phase order of the table: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] next_gray(input logic [1:0] g);
    case (g)
      2'b00:   next_gray = 2'b01;
      2'b01:   next_gray = 2'b11;
      2'b11:   next_gray = 2'b10;
      default: next_gray = 2'b00;
    endcase
  endfunction

`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Reset release synchronizer: start is only honoured once release has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  // Next-state and next-output computation for the sequencing FSM
  always_comb begin
    state_d         = state_q;
    gray_code_d     = gray_code_q;
    seq_data_addr_d = seq_data_addr_q;
    pass_cnt_d      = pass_cnt_q;
    repeat_d        = repeat_q;
    wht_vld_d       = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
    pass_inc        = pass_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        gray_code_d     = 2'b00;
        seq_data_addr_d = 3'd0;
        busy_d          = 1'b0;
        if (bus.start && sync_q[1]) begin
          state_d    = RUN;
          repeat_d   = (bus.num_repeat == 8'd0) ? 8'd1 : bus.num_repeat;
          pass_cnt_d = 8'd0;
          busy_d     = 1'b1;
        end
      end

      RUN: begin
        if (abort_hit) begin
          state_d         = DONE;
          done_d          = 1'b1;
          gray_code_d     = 2'b00;
          seq_data_addr_d = 3'd0;
        end else if (bus.rdy) begin
          wht_vld_d = 1'b1;
          if (seq_data_addr_q == LAST_ADDR) begin
            if (gray_code_q == LAST_GRAY) begin
              pass_cnt_d = pass_inc;
              if (pass_inc == repeat_q) begin
                state_d = DRAIN;
              end else begin
                gray_code_d     = 2'b00;
                seq_data_addr_d = 3'd0;
              end
            end else begin
              gray_code_d     = next_gray(gray_code_q);
              seq_data_addr_d = 3'd0;
            end
          end else begin
            seq_data_addr_d = seq_data_addr_q + 3'd1;
          end
        end
      end

      DRAIN: begin
        state_d         = DONE;
        done_d          = 1'b1;
        gray_code_d     = 2'b00;
        seq_data_addr_d = 3'd0;
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gray_code_q     <= 2'b00;
      seq_data_addr_q <= 3'd0;
      pass_cnt_q      <= 8'd0;
      repeat_q        <= 8'd0;
      wht_vld_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      gray_code_q     <= gray_code_d;
      seq_data_addr_q <= seq_data_addr_d;
      pass_cnt_q      <= pass_cnt_d;
      repeat_q        <= repeat_d;
      wht_vld_q       <= wht_vld_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.gray_code     = gray_code_q;
  assign bus.seq_data_addr = seq_data_addr_q;
  assign bus.wht_vld       = wht_vld_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// Self-checking bench for the weight sequence controller. A behavioural
// model tracks the run as an issue index into the flat 20*N entry list and
// derives (gray, addr) arithmetically; a compare process checks every cycle.
module tb_cnn_layer_accel_weight_seq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  cnn_layer_accel_weight_seq_ctrl_if bus ();

  cnn_layer_accel_weight_seq_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vld_seen = 0;
  int done_seen = 0;

  // Model state
  int         m_phase = 0;  // 0 idle, 1 running, 2 draining, 3 finished
  int         m_k     = 0;  // issues completed in this run
  int         m_total = 0;  // issues owed for this run
  int         m_sync  = 0;
  logic [1:0] exp_gray = 2'b00;
  logic [2:0] exp_addr = 3'd0;
  logic       exp_vld  = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Posedge counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural reference model
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_total = 0; m_sync = 0;
      exp_gray = 2'b00; exp_addr = 3'd0;
      exp_vld = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      exp_vld  = 1'b0;
      exp_done = 1'b0;
      case (m_phase)
        0: if (bus.start === 1'b1 && m_sync >= 2) begin
             m_phase = 1;
             m_total = 20 * ((bus.num_repeat == 8'd0) ? 1 : int'(bus.num_repeat));
             m_k = 0;
           end
        1: begin
`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
             if (bus.abort === 1'b1) begin
               m_phase = 3;
               exp_done = 1'b1;
             end else
`endif
             if (bus.rdy === 1'b1) begin
               exp_vld = 1'b1;
               m_k++;
               if (m_k == m_total) m_phase = 2;
             end
           end
        2: begin
             m_phase = 3;
             exp_done = 1'b1;
           end
        default: m_phase = 0;
      endcase
      if (m_sync < 2) m_sync++;
      exp_busy = (m_phase != 0);
      if (m_phase == 1) begin
        exp_gray = gray_tab[(m_k / 5) % 4];
        exp_addr = 3'(m_k % 5);
      end else if (m_phase == 2) begin
        exp_gray = gray_tab[((m_k - 1) / 5) % 4];
        exp_addr = 3'((m_k - 1) % 5);
      end else begin
        exp_gray = 2'b00;
        exp_addr = 3'd0;
      end
    end
  end

  // Per-cycle compare of DUT against model, sampled away from the active edge
  initial forever begin
    @(negedge clk);
    check_output("gray_code", 32'(bus.gray_code), 32'(exp_gray));
    check_output("seq_data_addr", 32'(bus.seq_data_addr), 32'(exp_addr));
    check_output("wht_vld", 32'(bus.wht_vld), 32'(exp_vld));
    check_output("busy", 32'(bus.busy), 32'(exp_busy));
    check_output("done", 32'(bus.done), 32'(exp_done));
    if (bus.wht_vld === 1'b1) vld_seen++;
    if (bus.done === 1'b1) done_seen++;
  end

  // One run: rdy_mode 0 = always 1, 1 = toggle 1,0, 2 = random
  task automatic apply_stimulus(input logic [7:0] nr, input int rdy_mode,
                                input bit poke_run, input bit poke_done, input int exp_pulses);
    int v0, d0, s0, eff, bound;
    bit seen;
    eff   = (nr == 8'd0) ? 1 : int'(nr);
    bound = 80 * eff + 40;
    seen  = 1'b0;
    @(negedge clk);
    v0 = vld_seen;
    d0 = done_seen;
    s0 = cyc;
    bus.num_repeat = nr;
    bus.start      = 1'b1;
    bus.rdy        = 1'b1;
    @(negedge clk);
    bus.num_repeat = 8'($urandom);
    for (int i = 0; i < bound; i++) begin
      case (rdy_mode)
        0:       bus.rdy = 1'b1;
        1:       bus.rdy = (i % 2 == 0);
        default: bus.rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.start = poke_run && (i == 4);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      failures++;
      checks++;
      $display("[TB] FAIL done_timeout: actual=none expected=done within %0d cycles", bound);
    end else if (rdy_mode == 0) begin
      check_output("done_latency", 32'(cyc - s0), 32'(20 * eff + 2));
    end
    bus.start = poke_done;
    bus.rdy   = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pulse_count", 32'(vld_seen - v0), 32'(exp_pulses));
    check_output("done_count", 32'(done_seen - d0), 32'd1);
  endtask

  // Async reset in the middle of a run, then a fresh run
  task automatic reset_mid_run();
    int d0;
    @(negedge clk);
    d0 = done_seen;
    bus.num_repeat = 8'd2;
    bus.start = 1'b1;
    bus.rdy   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_gray", 32'(bus.gray_code), 32'd0);
    check_output("rst_addr", 32'(bus.seq_data_addr), 32'd0);
    check_output("rst_vld", 32'(bus.wht_vld), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_no_done", 32'(done_seen - d0), 32'd0);
    apply_stimulus(8'd1, 0, 1'b0, 1'b0, 20);
  endtask

`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
  // Abort on the 10th issue (gray 01, addr 4)
  task automatic abort_run();
    int v0;
    @(negedge clk);
    v0 = vld_seen;
    bus.num_repeat = 8'd1;
    bus.start = 1'b1;
    bus.rdy   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_output("abort_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check_output("abort_idle", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    check_output("abort_pulses", 32'(vld_seen - v0), 32'd9);
  endtask
`endif

  initial begin
    bus.start      = 1'b0;
    bus.num_repeat = 8'd0;
    bus.rdy        = 1'b0;
`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
    bus.abort      = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    check_output("init_gray", 32'(bus.gray_code), 32'd0);
    check_output("init_addr", 32'(bus.seq_data_addr), 32'd0);
    check_output("init_vld", 32'(bus.wht_vld), 32'd0);
    check_output("init_busy", 32'(bus.busy), 32'd0);
    check_output("init_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] single pass, rdy constant");
    apply_stimulus(8'd1, 0, 1'b0, 1'b0, 20);
    $display("[TB] num_repeat zero");
    apply_stimulus(8'd0, 0, 1'b0, 1'b0, 20);
    $display("[TB] three passes, rdy toggling");
    apply_stimulus(8'd3, 1, 1'b0, 1'b0, 60);
    $display("[TB] start pokes during run and done");
    apply_stimulus(8'd2, 0, 1'b1, 1'b1, 40);
    $display("[TB] reset mid-run");
    reset_mid_run();
    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      logic [7:0] nr;
      nr = 8'($urandom_range(0, 4));
      apply_stimulus(nr, 2, 1'($urandom), 1'($urandom), 20 * ((nr == 8'd0) ? 1 : int'(nr)));
    end
    $display("[TB] 255 passes");
    apply_stimulus(8'd255, 0, 1'b0, 1'b0, 5100);
`ifdef CNN_LAYER_ACCEL_WSEQ_ABORT_EN
    $display("[TB] abort at issue 10");
    abort_run();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
